branch_target_predictor: RTL and testbench
==========================================

// Module: branch_target_predictor
// PURPOSE
//  Pipelined branch/jump target unit with a direct-mapped branch target buffer (BTB).
//  IF stage: looks up the fetch PC and returns a predicted next PC one cycle later.
//  EX stage: resolves the actual branch/J/JR target (PC+4 + sext(imm)<<2, or the jump
//  forms), flags mispredicts, and trains the BTB with 2-bit saturating counters.
// PARAMETERS
//  ADDR_W   32  PC / target width in bits (>= 30).
//  ENTRIES  16  BTB entries; power of 2, >= 2; IDX_W = log2(ENTRIES).
//  CNT_W    2   width of the saturating direction counter.
// PORTS
//  clk           in   1       rising-edge clock.
//  rst_n         in   1       asynchronous, active-low reset.
//  flush         in   1       kills any lookup response pending for the next cycle.
//  f_valid       in   1       IF lookup request.
//  f_pc          in   ADDR_W  fetch PC (word aligned).
//  p_valid       out  1       prediction valid (registered; 1 cycle after f_valid).
//  p_hit         out  1       BTB tag hit.
//  p_taken       out  1       hit AND counter MSB set.
//  p_next_pc     out  ADDR_W  p_taken ? stored target : f_pc+4.
//  r_valid       in   1       EX resolve request.
//  r_kind        in   2       00 none, 01 BR (conditional), 10 J, 11 JR.
//  r_pc          in   ADDR_W  PC of the resolving instruction.
//  r_imm         in   32      sign-extended immediate (BR).
//  r_index       in   26      instr_index field (J).
//  r_reg         in   ADDR_W  register target (JR).
//  r_cond        in   1       branch condition outcome (BR only).
//  r_pred_taken  in   1       p_taken carried down the pipe for this instruction.
//  r_pred_pc     in   ADDR_W  p_next_pc carried down the pipe.
//  x_valid       out  1       resolve result valid (registered; 1 cycle after r_valid).
//  x_mispredict  out  1       redirect required.
//  x_redirect_pc out  ADDR_W  correct next PC.
// BEHAVIOUR
//  Reset: all outputs 0; all BTB valid bits cleared; counters = 01 (weak not-taken).
//   Reset is asynchronous and may assert mid-operation; in-flight results are discarded.
//  Indexing: idx = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2].
//  Lookup: latency 1. p_valid = f_valid of the previous cycle AND NOT flush.
//   A miss gives p_hit=0, p_taken=0, p_next_pc=f_pc+4.
//  Targets: computed mod 2^ADDR_W; wrap-around is legal and not flagged.
//   BR: pc4 + (r_imm<<2), where pc4 = r_pc+4. J: {pc4[ADDR_W-1:28], r_index, 2'b00}. JR: r_reg.
//  Actual taken: BR = r_cond; J and JR = 1; kind 00 = 0.
//  Resolve: latency 1. x_redirect_pc = taken ? target : pc4.
//   x_mispredict = (taken != r_pred_taken) OR (taken AND target != r_pred_pc).
//   x_valid is 1 for every r_valid, including kind 00.
//  Training (same edge as the resolve register), for kind != 00 only:
//   Tag hit: counter +1 if taken, -1 if not; saturates at 0 and 2^CNT_W-1; target updated if taken.
//   Tag miss, taken: allocate (valid=1, tag, target); counter = 10 for BR, 11 for J/JR.
//   Tag miss, not taken: no allocation.
//  Simultaneous lookup and train on the same idx: the lookup returns the pre-update entry.
//  flush does not affect the resolve path or training.
// STRUCTURE
//  Shared package mips_bp_pkg: r_kind encodings (KIND_NONE/BR/J/JR), the counter reset
//   constant, and the taken-threshold constant.
//  Sub-module branch_target_calc (combinational): r_kind, pc4, r_imm, r_index, r_reg -> target.
//  The top level holds BTB arrays (valid/tag/target/counter), the lookup pipeline register,
//   and the resolve/training logic.
// TESTING
//  1. Reset, then lookup 0x0040_0000 -> p_valid=1, p_hit=0, p_taken=0, p_next_pc=0x0040_0004.
//  2. BR r_pc=0x0040_0010, imm=0xFFFF_FFFC, cond=1, pred_taken=0 -> x_mispredict=1,
//     x_redirect_pc=0x0040_0004; re-lookup 0x0040_0010 -> hit, taken, 0x0040_0004.
//  3. Same BR trained taken 3 times then not taken 3 times -> counter 11 then 00; p_taken follows MSB.
//  4. J r_pc=0x1FFF_FFFC, index=0x0000_100 -> target 0x2000_0400; redirect on pred miss;
//     wrap check: BR r_pc=0xFFFF_FFF8, imm=1 -> 0x0000_0000.
//  5. Aliasing: train 0x0040_0000, then JR at 0x0040_0040 (same idx, ENTRIES=16) -> entry
//     replaced; same-cycle lookup of that idx returns the old target.
//  6. Assert rst_n low mid-resolve, and flush with f_valid -> x_valid=0 and p_valid=0
//     next cycle; all entries miss.

Source files
------------

// File: rtl/mips_bp_pkg.sv
// Shared encodings and counter constants for the branch target predictor.
// The counter constants are written for the 2-bit case; wider counters scale them.
package mips_bp_pkg;

    localparam logic [1:0] KIND_NONE = 2'b00;
    localparam logic [1:0] KIND_BR   = 2'b01;
    localparam logic [1:0] KIND_J    = 2'b10;
    localparam logic [1:0] KIND_JR   = 2'b11;

    // Weak not-taken at reset; counters at or above the threshold predict taken.
    localparam logic [1:0] CNT_RESET        = 2'b01;
    localparam logic [1:0] CNT_TAKEN_THRESH = 2'b10;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational resolved-target calculation for BR, J and JR.
// Arithmetic wraps modulo 2^ADDR_W.
module branch_target_calc
    import mips_bp_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [1:0]        r_kind,
    input  logic [ADDR_W-1:0] pc4,
    input  logic [31:0]       r_imm,
    input  logic [25:0]       r_index,
    input  logic [ADDR_W-1:0] r_reg,
    output logic [ADDR_W-1:0] target
);

    logic [ADDR_W-1:0] imm_ext;

    always_comb begin
        imm_ext = ADDR_W'($signed(r_imm));
        case (r_kind)
            KIND_BR: target = pc4 + (imm_ext << 2);
            KIND_J:  target = {pc4[ADDR_W-1:28], r_index, 2'b00};
            KIND_JR: target = r_reg;
            default: target = pc4;
        endcase
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: registered IF lookup and
// registered EX resolve/mispredict, training the BTB on the resolve edge.
module branch_target_predictor
    import mips_bp_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CNT_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              f_valid,
    input  logic [ADDR_W-1:0] f_pc,
    output logic              p_valid,
    output logic              p_hit,
    output logic              p_taken,
    output logic [ADDR_W-1:0] p_next_pc,
    input  logic              r_valid,
    input  logic [1:0]        r_kind,
    input  logic [ADDR_W-1:0] r_pc,
    input  logic [31:0]       r_imm,
    input  logic [25:0]       r_index,
    input  logic [ADDR_W-1:0] r_reg,
    input  logic              r_cond,
    input  logic              r_pred_taken,
    input  logic [ADDR_W-1:0] r_pred_pc,
    output logic              x_valid,
    output logic              x_mispredict,
    output logic [ADDR_W-1:0] x_redirect_pc
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [CNT_W-1:0] CNT_TAKEN = CNT_W'(CNT_TAKEN_THRESH) << (CNT_W - 2);
    localparam logic [CNT_W-1:0] CNT_RST   = (CNT_W'(CNT_RESET) << (CNT_W - 2)) |
                                             ((CNT_W'(1) << (CNT_W - 2)) - CNT_W'(1));
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [TAG_W-1:0]   tag_d [ENTRIES];
    logic [ADDR_W-1:0]  tgt_q [ENTRIES];
    logic [ADDR_W-1:0]  tgt_d [ENTRIES];
    logic [CNT_W-1:0]   cnt_q [ENTRIES];
    logic [CNT_W-1:0]   cnt_d [ENTRIES];

    logic              p_valid_q, p_valid_d, p_hit_q, p_hit_d, p_taken_q, p_taken_d;
    logic [ADDR_W-1:0] p_next_pc_q, p_next_pc_d;
    logic              x_valid_q, x_valid_d, x_mispredict_q, x_mispredict_d;
    logic [ADDR_W-1:0] x_redirect_pc_q, x_redirect_pc_d;

    logic [IDX_W-1:0]  f_idx, r_idx;
    logic [TAG_W-1:0]  f_tag, r_tag;
    logic              f_hit, f_taken, r_hit, r_taken;
    logic [ADDR_W-1:0] f_pc4, r_pc4, r_target;

    branch_target_calc #(
        .ADDR_W (ADDR_W)
    ) u_calc (
        .r_kind  (r_kind),
        .pc4     (r_pc4),
        .r_imm   (r_imm),
        .r_index (r_index),
        .r_reg   (r_reg),
        .target  (r_target)
    );

    // Lookup reads the registered arrays, so a same-edge train is not visible yet.
    always_comb begin
        f_idx   = f_pc[IDX_W+1:2];
        f_tag   = f_pc[ADDR_W-1:IDX_W+2];
        f_pc4   = f_pc + ADDR_W'(4);
        f_hit   = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        f_taken = f_hit && (cnt_q[f_idx] >= CNT_TAKEN);

        p_valid_d   = f_valid && !flush;
        p_hit_d     = p_valid_d && f_hit;
        p_taken_d   = p_valid_d && f_taken;
        p_next_pc_d = !p_valid_d ? '0 : (f_taken ? tgt_q[f_idx] : f_pc4);
    end

    always_comb begin
        r_idx = r_pc[IDX_W+1:2];
        r_tag = r_pc[ADDR_W-1:IDX_W+2];
        r_pc4 = r_pc + ADDR_W'(4);
        r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
        case (r_kind)
            KIND_BR: r_taken = r_cond;
            KIND_J:  r_taken = 1'b1;
            KIND_JR: r_taken = 1'b1;
            default: r_taken = 1'b0;
        endcase

        x_valid_d       = r_valid;
        x_mispredict_d  = r_valid && ((r_taken != r_pred_taken) ||
                                      (r_taken && (r_target != r_pred_pc)));
        x_redirect_pc_d = !r_valid ? '0 : (r_taken ? r_target : r_pc4);

        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        if (r_valid && (r_kind != KIND_NONE)) begin
            if (r_hit) begin
                if (r_taken) begin
                    tgt_d[r_idx] = r_target;
                    if (cnt_q[r_idx] != CNT_MAX) cnt_d[r_idx] = cnt_q[r_idx] + CNT_W'(1);
                end else if (cnt_q[r_idx] != '0) begin
                    cnt_d[r_idx] = cnt_q[r_idx] - CNT_W'(1);
                end
            end else if (r_taken) begin
                valid_d[r_idx] = 1'b1;
                tag_d[r_idx]   = r_tag;
                tgt_d[r_idx]   = r_target;
                cnt_d[r_idx]   = (r_kind == KIND_BR) ? CNT_TAKEN : CNT_MAX;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                cnt_q[i] <= CNT_RST;
            end
            p_valid_q       <= 1'b0;
            p_hit_q         <= 1'b0;
            p_taken_q       <= 1'b0;
            p_next_pc_q     <= '0;
            x_valid_q       <= 1'b0;
            x_mispredict_q  <= 1'b0;
            x_redirect_pc_q <= '0;
        end else begin
            valid_q         <= valid_d;
            tag_q           <= tag_d;
            tgt_q           <= tgt_d;
            cnt_q           <= cnt_d;
            p_valid_q       <= p_valid_d;
            p_hit_q         <= p_hit_d;
            p_taken_q       <= p_taken_d;
            p_next_pc_q     <= p_next_pc_d;
            x_valid_q       <= x_valid_d;
            x_mispredict_q  <= x_mispredict_d;
            x_redirect_pc_q <= x_redirect_pc_d;
        end
    end

    assign p_valid       = p_valid_q;
    assign p_hit         = p_hit_q;
    assign p_taken       = p_taken_q;
    assign p_next_pc     = p_next_pc_q;
    assign x_valid       = x_valid_q;
    assign x_mispredict  = x_mispredict_q;
    assign x_redirect_pc = x_redirect_pc_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed vector bench for branch_target_predictor (ADDR_W=32, ENTRIES=16, CNT_W=2).
module tb_branch_target_predictor;

    logic        clk, rst_n, flush, f_valid;
    logic [31:0] f_pc;
    logic        p_valid, p_hit, p_taken;
    logic [31:0] p_next_pc;
    logic        r_valid;
    logic [1:0]  r_kind;
    logic [31:0] r_pc, r_imm;
    logic [25:0] r_index;
    logic [31:0] r_reg;
    logic        r_cond, r_pred_taken;
    logic [31:0] r_pred_pc;
    logic        x_valid, x_mispredict;
    logic [31:0] x_redirect_pc;

    int total = 0;
    int bad   = 0;

    branch_target_predictor #(
        .ADDR_W  (32),
        .ENTRIES (16),
        .CNT_W   (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .f_valid       (f_valid),
        .f_pc          (f_pc),
        .p_valid       (p_valid),
        .p_hit         (p_hit),
        .p_taken       (p_taken),
        .p_next_pc     (p_next_pc),
        .r_valid       (r_valid),
        .r_kind        (r_kind),
        .r_pc          (r_pc),
        .r_imm         (r_imm),
        .r_index       (r_index),
        .r_reg         (r_reg),
        .r_cond        (r_cond),
        .r_pred_taken  (r_pred_taken),
        .r_pred_pc     (r_pred_pc),
        .x_valid       (x_valid),
        .x_mispredict  (x_mispredict),
        .x_redirect_pc (x_redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fv;
        logic        fl;
        logic [31:0] fpc;
        logic        rv;
        logic [1:0]  kind;
        logic [31:0] rpc;
        logic [31:0] imm;
        logic [25:0] idx;
        logic [31:0] rreg;
        logic        cond;
        logic        ptk;
        logic [31:0] ppc;
        logic        e_pv;
        logic        e_hit;
        logic        e_tk;
        logic [31:0] e_npc;
        logic        e_xv;
        logic        e_mis;
        logic [31:0] e_red;
    } vec_t;

    localparam logic [1:0] K_NONE = 2'b00, K_BR = 2'b01, K_J = 2'b10, K_JR = 2'b11;

    function automatic vec_t blank();
        vec_t v;
        v.fv = 0; v.fl = 0; v.fpc = 0; v.rv = 0; v.kind = 0; v.rpc = 0; v.imm = 0;
        v.idx = 0; v.rreg = 0; v.cond = 0; v.ptk = 0; v.ppc = 0; v.e_pv = 0;
        v.e_hit = 0; v.e_tk = 0; v.e_npc = 0; v.e_xv = 0; v.e_mis = 0; v.e_red = 0;
        return v;
    endfunction

    function automatic vec_t lk(logic [31:0] pc, logic hit, logic tk, logic [31:0] npc);
        vec_t v = blank();
        v.fv = 1; v.fpc = pc; v.e_pv = 1; v.e_hit = hit; v.e_tk = tk; v.e_npc = npc;
        return v;
    endfunction

    function automatic vec_t fl(logic [31:0] pc);
        vec_t v = blank();
        v.fv = 1; v.fl = 1; v.fpc = pc;
        return v;
    endfunction

    function automatic vec_t rs(logic [1:0] k, logic [31:0] pc, logic [31:0] imm,
                                logic [25:0] ix, logic [31:0] rg, logic c, logic pt,
                                logic [31:0] pp, logic mis, logic [31:0] red);
        vec_t v = blank();
        v.rv = 1; v.kind = k; v.rpc = pc; v.imm = imm; v.idx = ix; v.rreg = rg;
        v.cond = c; v.ptk = pt; v.ppc = pp; v.e_xv = 1; v.e_mis = mis; v.e_red = red;
        return v;
    endfunction

    function automatic vec_t both(vec_t a, vec_t b);
        vec_t v = a;
        v.rv = b.rv; v.kind = b.kind; v.rpc = b.rpc; v.imm = b.imm; v.idx = b.idx;
        v.rreg = b.rreg; v.cond = b.cond; v.ptk = b.ptk; v.ppc = b.ppc;
        v.e_xv = b.e_xv; v.e_mis = b.e_mis; v.e_red = b.e_red;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        flush = 0; f_valid = 0; f_pc = 0; r_valid = 0; r_kind = 0; r_pc = 0; r_imm = 0;
        r_index = 0; r_reg = 0; r_cond = 0; r_pred_taken = 0; r_pred_pc = 0;
    endtask

    task automatic apply(input vec_t v, input int n);
        flush = v.fl; f_valid = v.fv; f_pc = v.fpc;
        r_valid = v.rv; r_kind = v.kind; r_pc = v.rpc; r_imm = v.imm; r_index = v.idx;
        r_reg = v.rreg; r_cond = v.cond; r_pred_taken = v.ptk; r_pred_pc = v.ppc;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d p_valid", n), 32'(p_valid), 32'(v.e_pv));
        if (v.e_pv) begin
            chk($sformatf("v%0d p_hit", n), 32'(p_hit), 32'(v.e_hit));
            chk($sformatf("v%0d p_taken", n), 32'(p_taken), 32'(v.e_tk));
            chk($sformatf("v%0d p_next_pc", n), p_next_pc, v.e_npc);
        end
        chk($sformatf("v%0d x_valid", n), 32'(x_valid), 32'(v.e_xv));
        if (v.e_xv) begin
            chk($sformatf("v%0d x_mispredict", n), 32'(x_mispredict), 32'(v.e_mis));
            chk($sformatf("v%0d x_redirect_pc", n), x_redirect_pc, v.e_red);
        end
        drive_idle();
    endtask

    vec_t vq[$];

    initial begin
        // Test-1/2: first lookup miss, then a backward BR allocates an entry.
        vq.push_back(lk(32'h0040_0000, 0, 0, 32'h0040_0004));
        vq.push_back(rs(K_BR, 32'h0040_0010, 32'hFFFF_FFFC, 0, 0, 1, 0, 32'h0040_0014,
                        1, 32'h0040_0004));
        vq.push_back(lk(32'h0040_0010, 1, 1, 32'h0040_0004));
        // Counter saturation up (10 -> 11 -> 11 -> 11).
        for (int i = 0; i < 3; i++)
            vq.push_back(rs(K_BR, 32'h0040_0010, 32'hFFFF_FFFC, 0, 0, 1, 1, 32'h0040_0004,
                            0, 32'h0040_0004));
        vq.push_back(lk(32'h0040_0010, 1, 1, 32'h0040_0004));
        // Walk down: 11 -> 10 -> 01 -> 00 -> 00.
        vq.push_back(rs(K_BR, 32'h0040_0010, 32'hFFFF_FFFC, 0, 0, 0, 1, 32'h0040_0004,
                        1, 32'h0040_0014));
        vq.push_back(lk(32'h0040_0010, 1, 1, 32'h0040_0004));
        vq.push_back(rs(K_BR, 32'h0040_0010, 32'hFFFF_FFFC, 0, 0, 0, 1, 32'h0040_0004,
                        1, 32'h0040_0014));
        vq.push_back(lk(32'h0040_0010, 1, 0, 32'h0040_0014));
        for (int i = 0; i < 2; i++)
            vq.push_back(rs(K_BR, 32'h0040_0010, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'h0040_0014,
                            0, 32'h0040_0014));
        vq.push_back(lk(32'h0040_0010, 1, 0, 32'h0040_0014));
        // Back up from 00: one taken gives 01 (still not taken), second gives 10.
        vq.push_back(rs(K_BR, 32'h0040_0010, 32'hFFFF_FFFC, 0, 0, 1, 0, 32'h0040_0014,
                        1, 32'h0040_0004));
        vq.push_back(lk(32'h0040_0010, 1, 0, 32'h0040_0014));
        vq.push_back(rs(K_BR, 32'h0040_0010, 32'hFFFF_FFFC, 0, 0, 1, 0, 32'h0040_0014,
                        1, 32'h0040_0004));
        vq.push_back(lk(32'h0040_0010, 1, 1, 32'h0040_0004));
        // Test-4: J across a 256 MB region boundary, then correct/wrong-target predictions.
        vq.push_back(rs(K_J, 32'h1FFF_FFFC, 0, 26'h100, 0, 0, 0, 32'h2000_0000,
                        1, 32'h2000_0400));
        vq.push_back(lk(32'h1FFF_FFFC, 1, 1, 32'h2000_0400));
        vq.push_back(rs(K_J, 32'h1FFF_FFFC, 0, 26'h100, 0, 0, 1, 32'h2000_0400,
                        0, 32'h2000_0400));
        vq.push_back(rs(K_J, 32'h1FFF_FFFC, 0, 26'h100, 0, 0, 1, 32'h2000_0404,
                        1, 32'h2000_0400));
        // Address wrap-around.
        vq.push_back(rs(K_BR, 32'hFFFF_FFF8, 32'h1, 0, 0, 1, 1, 32'h0, 0, 32'h0));
        vq.push_back(lk(32'hFFFF_FFF8, 1, 1, 32'h0));
        // Not-taken miss does not allocate; kind 00 is valid but never trains.
        vq.push_back(rs(K_BR, 32'h0040_0020, 32'h5, 0, 0, 0, 0, 32'h0040_0024,
                        0, 32'h0040_0024));
        vq.push_back(lk(32'h0040_0020, 0, 0, 32'h0040_0024));
        vq.push_back(rs(K_NONE, 32'h0040_0030, 0, 0, 0, 0, 1, 32'h0000_1234,
                        1, 32'h0040_0034));
        vq.push_back(lk(32'h0040_0030, 0, 0, 32'h0040_0034));
        // Test-5: aliasing at idx 0 with same-cycle lookup seeing the old entry.
        vq.push_back(rs(K_BR, 32'h0040_0000, 32'h10, 0, 0, 1, 0, 32'h0040_0004,
                        1, 32'h0040_0044));
        vq.push_back(lk(32'h0040_0000, 1, 1, 32'h0040_0044));
        vq.push_back(both(lk(32'h0040_0000, 1, 1, 32'h0040_0044),
                          rs(K_JR, 32'h0040_0040, 0, 0, 32'h00AB_CDE0, 0, 0, 32'h0040_0044,
                             1, 32'h00AB_CDE0)));
        vq.push_back(lk(32'h0040_0000, 0, 0, 32'h0040_0004));
        vq.push_back(lk(32'h0040_0040, 1, 1, 32'h00AB_CDE0));
        // Flush kills the lookup but not the resolve or its training.
        vq.push_back(both(fl(32'h0040_0040),
                          rs(K_BR, 32'h0040_0020, 32'h5, 0, 0, 1, 0, 32'h0040_0024,
                             1, 32'h0040_0038)));
        vq.push_back(lk(32'h0040_0020, 1, 1, 32'h0040_0038));

        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset p_valid", 32'(p_valid), 0);
        chk("reset p_hit", 32'(p_hit), 0);
        chk("reset p_taken", 32'(p_taken), 0);
        chk("reset p_next_pc", p_next_pc, 0);
        chk("reset x_valid", 32'(x_valid), 0);
        chk("reset x_mispredict", 32'(x_mispredict), 0);
        chk("reset x_redirect_pc", x_redirect_pc, 0);
        #2 rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

        // Test-6: asynchronous reset lands while a lookup and a resolve are in flight.
        f_valid = 1; f_pc = 32'h0040_0020;
        r_valid = 1; r_kind = K_BR; r_pc = 32'h0040_0010; r_imm = 32'hFFFF_FFFC; r_cond = 1;
        #3 rst_n = 1'b0;
        #1;
        chk("async rst p_valid", 32'(p_valid), 0);
        chk("async rst x_valid", 32'(x_valid), 0);
        @(posedge clk);
        #1;
        chk("rst edge p_valid", 32'(p_valid), 0);
        chk("rst edge x_valid", 32'(x_valid), 0);
        drive_idle();
        #2 rst_n = 1'b1;
        apply(lk(32'h0040_0020, 0, 0, 32'h0040_0024), 100);
        apply(lk(32'h0040_0010, 0, 0, 32'h0040_0014), 101);
        apply(lk(32'h0040_0040, 0, 0, 32'h0040_0044), 102);
        apply(lk(32'h1FFF_FFFC, 0, 0, 32'h2000_0000), 103);
        apply(lk(32'hFFFF_FFF8, 0, 0, 32'hFFFF_FFFC), 104);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
